// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and the future receiver.
//   uart_state_t : serialiser frame state
//   baud_div()   : clock cycles per bit time (integer divide)
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, DEPTH entries (power of two, >= 2), all usable.
// Ports:
//   clk, rst            clock, async active-high reset (empties the FIFO)
//   push, push_data     write request; ignored while full
//   pop, pop_data       read request; pop_data shows the head (valid when !empty)
//   full, empty         registered status flags
//   level               occupancy 0..DEPTH
module sync_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;
  logic [LW-1:0]    lvl_nxt;

  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_comb begin
    lvl_nxt = level;
    case ({do_push, do_pop})
      2'b10:   lvl_nxt = level + 1'b1;
      2'b01:   lvl_nxt = level - 1'b1;
      default: lvl_nxt = level;
    endcase
  end

  // storage needs no reset: empty flag guards every read
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= push_data;

  // pointers wrap naturally since DEPTH is a power of two; flags are
  // computed from the next level so they stay glitch-free registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= lvl_nxt;
      full  <= (lvl_nxt == LW'(DEPTH));
      empty <= (lvl_nxt == '0);
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter, LSB first.
// Ports:
//   clk, rst            system clock, async active-high reset
//   in_data/in_valid    byte stream in; accepted when in_valid & in_ready
//   in_ready            FIFO not full (registered)
//   uart_tx             serial line, idle high, registered
//   busy                frame in progress or bytes queued
//   level               FIFO occupancy 0..DEPTH
//   overflow            sticky: a byte was offered while in_ready was low
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 64,
  parameter int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             uart_tx,
  output logic             busy,
  output logic [LVL_W-1:0] level,
  output logic             overflow
);

  localparam int BAUD_DIV = baud_div(CLK_HZ, BAUD);
  localparam int BW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BAUD_TC = BW'(BAUD_DIV - 1);

  uart_state_t   state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg, fifo_dout;
  logic          fifo_full, fifo_empty, baud_tc, pop, tx_q;

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  assign baud_tc  = (baud_cnt == BAUD_TC);
  // pop from IDLE, or on the last stop-bit cycle so frames abut
  assign pop      = ~fifo_empty & ((state == IDLE) | ((state == STOP) & baud_tc));
  assign in_ready = ~fifo_full;
  assign uart_tx  = tx_q;
  assign busy     = (state != IDLE) | (level != '0);

  // tx_q follows the state one cycle later; every state lasts BAUD_DIV
  // cycles so the line keeps exact bit timing, just shifted by one clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx_q     <= 1'b1;
    end else begin
      case (state)
        START:   tx_q <= 1'b0;
        DATA:    tx_q <= shreg[bit_cnt];
        default: tx_q <= 1'b1;
      endcase

      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            shreg    <= fifo_dout;
            baud_cnt <= '0;
            state    <= START;
          end
        end
        START: begin
          if (baud_tc) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_tc) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) state   <= STOP;
            else                 bit_cnt <= bit_cnt + 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_tc) begin
            baud_cnt <= '0;
            if (!fifo_empty) begin
              shreg <= fifo_dout;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        overflow <= 1'b0;
    else if (in_valid && !in_ready) overflow <= 1'b1;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready, uart_tx, busy, overflow;
  logic [2:0] level;

  uart_tx_fifo #(.CLK_HZ(1_000_000), .BAUD(100_000), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .uart_tx(uart_tx), .busy(busy),
    .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0, n_rx = 0;
  bit mon_en = 1'b1;
  bit exp_ovf = 1'b0;
  logic [7:0] exp_q[$];   // bytes accepted, not yet seen on the line
  int         st_q[$];    // cycle index of each decoded start bit

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Line monitor: decodes 8N1 frames (10 cycles per bit) sampling at mid-bit
  // and scores them against the accepted-byte queue.
  initial begin : mon
    int t0;
    logic [7:0] b;
    bit ok;
    forever begin
      @(negedge clk);
      if (mon_en && !rst && uart_tx === 1'b0) begin
        t0 = cyc; b = '0; ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
          if (ok) begin
            repeat ((k == 0) ? 4 : 10) @(negedge clk);
            if (!mon_en || rst) ok = 1'b0;
            else if (k == 0)    chk("mon_start_bit", uart_tx, 0);
            else if (k < 9)     b[k-1] = uart_tx;
            else                chk("mon_stop_bit", uart_tx, 1);
          end
        end
        if (ok) begin
          st_q.push_back(t0);
          n_rx++;
          if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL rx_unexpected: got byte %02h with none queued", b);
          end else begin
            chk("rx_byte", b, exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic offer(input logic [7:0] d, output bit acc);
    in_valid = 1'b1; in_data = d;
    acc = in_ready;
    if (acc) exp_q.push_back(d);
    else     exp_ovf = 1'b1;
    @(negedge clk);
  endtask

  task automatic push_honor(input logic [7:0] d);
    int t = 0;
    bit acc;
    in_valid = 1'b0;
    while (!in_ready && t < 500) begin @(negedge clk); t++; end
    chk("push_wait_timeout", (t < 500), 1);
    offer(d, acc);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string nm, input int maxc);
    int t = 0;
    in_valid = 1'b0;
    while ((exp_q.size() != 0 || busy) && t < maxc) begin @(negedge clk); t++; end
    chk(nm, (t < maxc), 1);
    repeat (12) @(negedge clk);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_frames(input int n);
    int t = 0;
    while (st_q.size() < n && t < 400) begin @(negedge clk); t++; end
    chk("frame_start_timeout", (t < 400), 1);
  endtask

  typedef struct {
    int   off;    // cycles after the accepting edge
    logic tx;
    logic bsy;
    int   lvl;
  } vec_t;

  initial begin : main
    vec_t tbl[13];
    logic [9:0] pat;
    int N, acc_n, rx_base, guard;
    bit acc;

    // ---------------- reset values ----------------
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_uart_tx", uart_tx, 1);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // ---------------- 1: single byte 0x41, table-driven ----------------
    pat = 10'b1010000010;   // line bits 0..9: 0,1,0,0,0,0,0,1,0,1
    tbl[0] = '{0, 1'b1, 1'b1, 1};
    tbl[1] = '{1, 1'b1, 1'b1, 0};
    for (int k = 0; k < 10; k++) tbl[2+k] = '{2 + 5 + 10*k, pat[k], 1'b1, 0};
    tbl[12] = '{115, 1'b1, 1'b0, 0};
    st_q.delete();
    offer(8'h41, acc);
    in_valid = 1'b0;
    N = cyc;
    for (int i = 0; i < 13; i++) begin
      wait_cyc(N + tbl[i].off);
      chk($sformatf("t1_tx_at_%0d", tbl[i].off), uart_tx, tbl[i].tx);
      chk($sformatf("t1_busy_at_%0d", tbl[i].off), busy, tbl[i].bsy);
      chk($sformatf("t1_level_at_%0d", tbl[i].off), level, tbl[i].lvl);
    end
    wait_frames(1);
    chk("t1_start_latency", st_q[0] - N, 2);
    drain("t1_drain", 400);

    // ---------------- 2: three back-to-back frames ----------------
    st_q.delete();
    offer(8'h30, acc);
    N = cyc;
    offer(8'h31, acc);
    offer(8'h0A, acc);
    in_valid = 1'b0;
    chk("t2_level_after_pushes", level, 2);
    wait_cyc(N + 105);
    chk("t2_level_after_pop2", level, 1);
    wait_cyc(N + 205);
    chk("t2_level_after_pop3", level, 0);
    wait_frames(3);
    chk("t2_first_start", st_q[0] - N, 2);
    chk("t2_gap_1_2", st_q[1] - st_q[0], 100);
    chk("t2_gap_2_3", st_q[2] - st_q[1], 100);
    drain("t2_drain", 500);

    // ---------------- 4: push+pop same cycle, pointer wrap ----------------
    offer(8'hC0, acc);
    N = cyc;
    offer(8'hC1, acc);
    offer(8'hC2, acc);
    in_valid = 1'b0;
    wait_cyc(N + 100);
    chk("t4_level_before", level, 2);
    offer(8'hC3, acc);      // lands on the same edge as the second pop
    in_valid = 1'b0;
    chk("t4_accept", acc, 1);
    chk("t4_level_pushpop", level, 2);
    for (int i = 4; i < 12; i++) push_honor(8'hC0 + 8'(i));
    drain("t4_drain", 2000);

    // ---------------- 3: hold in_valid into a full FIFO ----------------
    acc_n = 0;
    rx_base = n_rx;
    for (int i = 0; i < 8; i++) begin
      offer(8'h50 + 8'(i), acc);
      if (!acc) break;
      acc_n++;
    end
    in_valid = 1'b0;
    chk("t3_accepted", acc_n, 5);
    chk("t3_level_full", level, 4);
    chk("t3_in_ready_low", in_ready, 0);
    chk("t3_overflow_set", overflow, exp_ovf);
    drain("t3_drain", 1000);
    chk("t3_rx_count", n_rx - rx_base, 5);
    chk("t3_overflow_sticky", overflow, 1);

    // ---------------- 5: reset during data bit 3 ----------------
    offer(8'hA5, acc);
    N = cyc;
    offer(8'h3C, acc);
    in_valid = 1'b0;
    wait_cyc(N + 45);
    chk("t5_pre_rst_tx", uart_tx, 0);   // bit 3 of 0xA5
    chk("t5_pre_rst_level", level, 1);
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_rst_tx", uart_tx, 1);
    chk("t5_rst_level", level, 0);
    chk("t5_rst_overflow", overflow, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_in_ready", in_ready, 1);
    exp_q.delete();
    exp_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("t5_idle_line", uart_tx, 1);
    mon_en = 1'b1;
    st_q.delete();
    rx_base = n_rx;
    offer(8'h5A, acc);
    in_valid = 1'b0;
    N = cyc;
    wait_frames(1);
    chk("t5_start_latency", st_q[0] - N, 2);
    drain("t5_drain", 400);
    chk("t5_rx_count", n_rx - rx_base, 1);

    // ---------------- 6: random stream, producer honours in_ready ----------------
    acc_n = 0;
    guard = 0;
    rx_base = n_rx;
    while (acc_n < 200 && guard < 60000) begin
      if ($urandom_range(0, 2) != 0 && in_ready) begin
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        exp_q.push_back(in_data);
        acc_n++;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    chk("t6_offered", acc_n, 200);
    drain("t6_drain", 30000);
    chk("t6_rx_count", n_rx - rx_base, 200);
    chk("t6_overflow", overflow, exp_ovf);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
